uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between `N_REQ` independent requesters (CPU store path, debug/log engine, etc.) using round-robin arbitration. The block sits between the requesters and the UART TX datapath. It latches the winning byte, issues a one-cycle start strobe and waits for the transmitter's done flag. It then optionally enforces an inter-frame gap and acknowledges the winner with a one-cycle done pulse.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART TX arbiter.
// The arbiter uses the slave modport; requesters and the UART TX model use master.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_i;
    logic [N_REQ*DATA_W-1:0] data_i;
    logic [N_REQ-1:0]        done_o;
    logic                    busy_o;
    logic                    tx_start_o;
    logic [DATA_W-1:0]       tx_data_o;
    logic                    tx_done_i;

    modport slave (
        input  req_i, data_i, tx_done_i,
        output done_o, busy_o, tx_start_o, tx_data_o
    );

    modport master (
        output req_i, data_i, tx_done_i,
        input  done_o, busy_o, tx_start_o, tx_data_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ requesters.
// Define UART_ARB_GAP_EN to insert GAP_CYCLES idle cycles after every frame.
module uart_tx_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 100_000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uart_tx_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_DONE,
`ifdef UART_ARB_GAP_EN
        S_GAP,
`endif
        S_ACK
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [IDX_W-1:0]  r_win;
    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  w_pick;
    logic [DATA_W-1:0] r_txData;
    logic [DATA_W-1:0] w_bytes [N_REQ];
    logic [N_REQ-1:0]  w_done;

    // A GAP_CYCLES below 1 would leave the GAP state nothing to count.
    if (GAP_CYCLES < 1) begin : g_badGapCycles
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign w_bytes[g] = bus.data_i[g*DATA_W +: DATA_W];
    end

    // Lowest requester above r_last wins; the second loop overrides the wrap-around pick.
    always_comb begin
        w_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_i[k] && k <= int'(r_last)) w_pick = IDX_W'(k);
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_i[k] && k > int'(r_last)) w_pick = IDX_W'(k);
        end
    end

`ifdef UART_ARB_GAP_EN
    localparam int CNT_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_gapCnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gapCnt <= '0;
        end else if (r_state == S_WAIT_DONE && bus.tx_done_i) begin
            r_gapCnt <= CNT_W'(GAP_CYCLES);
        end else if (r_state == S_GAP && r_gapCnt != '0) begin
            r_gapCnt <= r_gapCnt - CNT_ONE;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            S_IDLE:      if (|bus.req_i) w_nextState = S_LOAD;
            S_LOAD:      w_nextState = S_START;
            S_START:     w_nextState = S_WAIT_DONE;
`ifdef UART_ARB_GAP_EN
            S_WAIT_DONE: if (bus.tx_done_i) w_nextState = S_GAP;
            S_GAP:       if (r_gapCnt <= CNT_ONE) w_nextState = S_ACK;
`else
            S_WAIT_DONE: if (bus.tx_done_i) w_nextState = S_ACK;
`endif
            S_ACK:       w_nextState = S_IDLE;
            default:     w_nextState = S_IDLE;
        endcase
    end

    // The winner is frozen in IDLE so a requester dropping req mid-frame still gets its done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_win    <= '0;
            r_last   <= LAST_RESET;
            r_txData <= '0;
        end else begin
            if (r_state == S_IDLE && |bus.req_i) r_win <= w_pick;
            if (r_state == S_LOAD)               r_txData <= w_bytes[r_win];
            if (r_state == S_ACK)                r_last <= r_win;
        end
    end

    always_comb begin
        w_done = '0;
        if (r_state == S_ACK) w_done[r_win] = 1'b1;
    end

    assign bus.done_o     = w_done;
    assign bus.busy_o     = (r_state != S_IDLE);
    assign bus.tx_start_o = (r_state == S_START);
    assign bus.tx_data_o  = r_txData;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a queue of expected frames.
// Expected latencies follow UART_ARB_GAP_EN when it is defined for the build.
module tb_uart_tx_arbiter;
    localparam int N_REQ      = 2;
    localparam int DATA_W     = 8;
    localparam int GAP_CYCLES = 4;
`ifdef UART_ARB_GAP_EN
    localparam int GAP_LAT = GAP_CYCLES;
`else
    localparam int GAP_LAT = 0;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [N_REQ-1:0]  done;
    } frame_t;

    logic   clk_i = 1'b0;
    logic   rst_i;
    int     assertCnt = 0;
    int     failCnt   = 0;
    int     tickCnt   = 0;
    int     refTick   = 0;
    int     lastModel = N_REQ - 1;
    frame_t sbQ [$];

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N_REQ),
        .DATA_W(DATA_W),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk_i);
        tickCnt++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCnt++;
        if (actual !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int rrPick(input logic [N_REQ-1:0] req, input int last);
        for (int i = 1; i <= N_REQ; i++) begin
            if (req[(last + i) % N_REQ]) return (last + i) % N_REQ;
        end
        return 0;
    endfunction

    // Drive a held request and queue the frames it is expected to produce.
    task automatic applyStimulus(input logic [N_REQ-1:0] req, input logic [N_REQ*DATA_W-1:0] data,
                                 input int nFrames);
        frame_t f;
        int     w;
        bus.req_i  = req;
        bus.data_i = data;
        refTick    = tickCnt;
        for (int n = 0; n < nFrames; n++) begin
            w      = rrPick(req, lastModel);
            f.data = data[w*DATA_W +: DATA_W];
            f.done = N_REQ'(1) << w;
            sbQ.push_back(f);
            lastModel = w;
        end
    endtask

    task automatic waitStart(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.tx_start_o === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic serveFrame(input int doneDelay, input int expLat, input bit spur);
        frame_t exp;
        bit     ok;
        int     txT;
        int     doneT;
        waitStart(ok);
        checkOutput("startSeen", 32'(ok), 1);
        exp = sbQ.pop_front();
        checkOutput("startLat", tickCnt - refTick, expLat);
        checkOutput("txData", bus.tx_data_o, exp.data);
        checkOutput("busyStart", bus.busy_o, 1);
        if (spur) bus.tx_done_i = 1'b1;
        tick();
        bus.tx_done_i = 1'b0;
        checkOutput("startPulse", bus.tx_start_o, 0);
        for (int i = 1; i < doneDelay; i++) tick();
        checkOutput("noEarlyDone", bus.done_o, 0);
        checkOutput("busyWait", bus.busy_o, 1);
        bus.tx_done_i = 1'b1;
        txT = tickCnt;
        tick();
        bus.tx_done_i = spur;
        for (int k = 0; k < 200 && bus.done_o == '0; k++) begin
            tick();
            bus.tx_done_i = 1'b0;
        end
        checkOutput("doneLat", tickCnt - txT, GAP_LAT + 1);
        checkOutput("doneVec", bus.done_o, exp.done);
        checkOutput("txDataHold", bus.tx_data_o, exp.data);
        doneT = tickCnt;
        tick();
        bus.tx_done_i = 1'b0;
        checkOutput("donePulse", bus.done_o, 0);
        refTick = doneT;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        rst_i         = 1'b1;
        bus.req_i     = '0;
        bus.data_i    = '0;
        bus.tx_done_i = 1'b0;
        repeat (3) tick();
        checkOutput("rstBusy", bus.busy_o, 0);
        checkOutput("rstStart", bus.tx_start_o, 0);
        checkOutput("rstDone", bus.done_o, 0);
        checkOutput("rstData", bus.tx_data_o, 0);
        rst_i = 1'b0;
        tick();

        $display("[TB] single request");
        applyStimulus(2'b01, 16'h0055, 1);
        serveFrame(10, 2, 1'b0);
        bus.req_i = '0;
        repeat (2) tick();

        $display("[TB] simultaneous requests after reset");
        rst_i = 1'b1;
        tick();
        rst_i     = 1'b0;
        lastModel = N_REQ - 1;
        tick();
        applyStimulus(2'b11, 16'hB2A1, 2);
        serveFrame(3, 2, 1'b0);
        serveFrame(7, 3, 1'b0);
        bus.req_i = '0;
        repeat (2) tick();

        $display("[TB] six held frames");
        applyStimulus(2'b11, 16'hC4C3, 6);
        serveFrame($urandom_range(1, 12), 2, 1'b0);
        for (int n = 1; n < 6; n++) serveFrame($urandom_range(1, 12), 3, 1'b0);
        bus.req_i = '0;
        repeat (2) tick();

        $display("[TB] spurious tx_done");
        for (int i = 0; i < 3; i++) begin
            bus.tx_done_i = 1'b1;
            tick();
            bus.tx_done_i = 1'b0;
            checkOutput("idleBusy", bus.busy_o, 0);
            checkOutput("idleDone", bus.done_o, 0);
        end
        applyStimulus(2'b10, 16'h3C00, 1);
        serveFrame(8, 2, 1'b1);
        bus.req_i = '0;
        repeat (2) tick();

        $display("[TB] reset during WAIT_DONE");
        applyStimulus(2'b01, 16'h0077, 1);
        serveFrame(4, 2, 1'b0);
        applyStimulus(2'b11, 16'hD2D1, 1);
        waitStart(ok);
        checkOutput("abortStartSeen", 32'(ok), 1);
        checkOutput("abortData", bus.tx_data_o, 8'hD2);
        repeat (2) tick();
        rst_i = 1'b1;
        tick();
        checkOutput("abortBusy", bus.busy_o, 0);
        checkOutput("abortStart", bus.tx_start_o, 0);
        checkOutput("abortDone", bus.done_o, 0);
        rst_i     = 1'b0;
        bus.req_i = '0;
        lastModel = N_REQ - 1;
        sbQ.delete();
        repeat (3) tick();
        checkOutput("abortNoDone", bus.done_o, 0);
        applyStimulus(2'b11, 16'hE2E1, 1);
        serveFrame(5, 2, 1'b0);
        bus.req_i = '0;
        repeat (2) tick();
        applyStimulus(2'b10, 16'h9A00, 1);
        serveFrame(6, 2, 1'b0);
        bus.req_i = '0;
        repeat (3) tick();
        checkOutput("finalIdle", bus.busy_o, 0);
        checkOutput("sbDrained", sbQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end
endmodule
